// File: rtl/axis_egress_drop_filter.sv
// Filters P4 pipeline egress: packets whose first-beat dst-port byte is zero are discarded, the rest are forwarded.
// Beats reach m_axis one cycle after accept; a 2-entry skid buffer stalls s_axis when full, except while discarding.
module axis_egress_drop_filter #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_CNT_WIDTH        = 32
) (
   input  logic                            axis_aclk,
   input  logic                            axis_arst,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   input  logic                            clear_counts,
   output logic [C_CNT_WIDTH-1:0]          pkt_pass_count,
   output logic [C_CNT_WIDTH-1:0]          pkt_drop_count
);
   localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;
   localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {SOP, PASS, DROP} state_t;
   state_t state, state_nxt;

   logic [C_AXIS_DATA_WIDTH-1:0]  buf_data [2];
   logic [KEEP_W-1:0]             buf_keep [2];
   logic [C_AXIS_TUSER_WIDTH-1:0] buf_user [2];
   logic [1:0]                    buf_last;
   logic                          rd_ptr;
   logic                          wr_ptr;
   logic [1:0]                    occ;

   logic full, empty, accept, pop, dst_nonzero;
   logic wr_en, inc_pass, inc_drop;
   logic [C_AXIS_TUSER_WIDTH-1:0] wr_user;

   assign full          = (occ == 2'd2);
   assign empty         = (occ == 2'd0);
   // A packet being discarded never touches the buffer, so it may drain even while the buffer is full.
   assign s_axis_tready = ~axis_arst & ((state == DROP) | ~full);
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign pop           = ~empty & m_axis_tready;
   assign dst_nonzero   = (s_axis_tuser[31:24] != 8'd0);

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_user   = '0;
      inc_pass  = 1'b0;
      inc_drop  = 1'b0;
      if (accept) begin
         case (state)
            SOP: begin
               if (dst_nonzero) begin
                  wr_en   = 1'b1;
                  wr_user = s_axis_tuser;
                  if (s_axis_tlast) inc_pass  = 1'b1;
                  else              state_nxt = PASS;
               end else begin
                  if (s_axis_tlast) inc_drop  = 1'b1;
                  else              state_nxt = DROP;
               end
            end
            PASS: begin
               wr_en = 1'b1;
               if (s_axis_tlast) begin
                  inc_pass  = 1'b1;
                  state_nxt = SOP;
               end
            end
            DROP: begin
               if (s_axis_tlast) begin
                  inc_drop  = 1'b1;
                  state_nxt = SOP;
               end
            end
            default: state_nxt = SOP;
         endcase
      end
   end

   always_ff @(posedge axis_aclk or posedge axis_arst) begin
      if (axis_arst) state <= SOP;
      else           state <= state_nxt;
   end

   always_ff @(posedge axis_aclk or posedge axis_arst) begin
      if (axis_arst) begin
         for (int i = 0; i < 2; i++) begin
            buf_data[i] <= '0;
            buf_keep[i] <= '0;
            buf_user[i] <= '0;
         end
         buf_last <= '0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         occ      <= 2'd0;
      end else begin
         if (wr_en) begin
            buf_data[wr_ptr] <= s_axis_tdata;
            buf_keep[wr_ptr] <= s_axis_tkeep;
            buf_user[wr_ptr] <= wr_user;
            buf_last[wr_ptr] <= s_axis_tlast;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, wr_en} - {1'b0, pop};
      end
   end

   assign m_axis_tdata  = buf_data[rd_ptr];
   assign m_axis_tkeep  = buf_keep[rd_ptr];
   assign m_axis_tuser  = buf_user[rd_ptr];
   assign m_axis_tlast  = buf_last[rd_ptr];
   assign m_axis_tvalid = ~empty;

   always_ff @(posedge axis_aclk or posedge axis_arst) begin
      if (axis_arst) begin
         pkt_pass_count <= '0;
         pkt_drop_count <= '0;
      end else if (clear_counts) begin
         pkt_pass_count <= '0;
         pkt_drop_count <= '0;
      end else begin
         if (inc_pass && pkt_pass_count != CNT_MAX) pkt_pass_count <= pkt_pass_count + CNT_ONE;
         if (inc_drop && pkt_drop_count != CNT_MAX) pkt_drop_count <= pkt_drop_count + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_axis_egress_drop_filter.sv
// Directed bench for axis_egress_drop_filter with narrow data and 4-bit counters.
module tb_axis_egress_drop_filter;
   localparam int DW = 64;
   localparam int UW = 128;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   s_tdata = '0;
   logic [DW/8-1:0] s_tkeep = '0;
   logic [UW-1:0]   s_tuser = '0;
   logic            s_tvalid = 1'b0;
   logic            s_tready;
   logic            s_tlast = 1'b0;
   logic [DW-1:0]   m_tdata;
   logic [DW/8-1:0] m_tkeep;
   logic [UW-1:0]   m_tuser;
   logic            m_tvalid;
   logic            m_tready = 1'b0;
   logic            m_tlast;
   logic            clear = 1'b0;
   logic [CW-1:0]   pass_cnt;
   logic [CW-1:0]   drop_cnt;

   axis_egress_drop_filter #(
      .C_AXIS_DATA_WIDTH (DW),
      .C_AXIS_TUSER_WIDTH(UW),
      .C_CNT_WIDTH       (CW)
   ) dut (
      .axis_aclk     (clk),
      .axis_arst     (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tuser  (m_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .clear_counts  (clear),
      .pkt_pass_count(pass_cnt),
      .pkt_drop_count(drop_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int last_waits = 0;
   int vld_seen = 0;
   int base = 0;
   int vbase = 0;

   logic [DW-1:0]   q_data [$];
   logic [DW/8-1:0] q_keep [$];
   logic [UW-1:0]   q_user [$];
   logic            q_last [$];

   // Output handshakes are logged on the falling edge; the transfer completes on the following rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_tvalid) vld_seen++;
         if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_keep.push_back(m_tkeep);
            q_user.push_back(m_tuser);
            q_last.push_back(m_tlast);
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int idx, input logic [DW-1:0] d,
                          input logic [UW-1:0] u, input logic [DW/8-1:0] k, input logic l);
      if (idx < q_data.size()) begin
         chk({tag, "_data"}, 128'(q_data[idx]), 128'(d));
         chk({tag, "_user"}, 128'(q_user[idx]), 128'(u));
         chk({tag, "_keep"}, 128'(q_keep[idx]), 128'(k));
         chk({tag, "_last"}, 128'(q_last[idx]), 128'(l));
      end else begin
         total++;
         bad++;
         $error("FAIL %s missing beat observed=%0d expected>%0d", tag, q_data.size(), idx);
      end
   endtask

   // Presents one beat starting #1 after a rising edge and returns #1 after the edge that accepts it.
   task automatic beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                       input logic [DW/8-1:0] k, input logic l);
      int n = 0;
      s_tdata  = d;
      s_tuser  = u;
      s_tkeep  = k;
      s_tlast  = l;
      s_tvalid = 1'b1;
      @(negedge clk);
      while (!s_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $error("FAIL beat_timeout observed=stalled expected=accept");
      end
      last_waits = n;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic idle(input int cycles);
      s_tvalid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_s_tready", 128'(s_tready), 128'(0));
      chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_m_tdata",  128'(m_tdata),  128'(0));
      chk("rst_m_tuser",  128'(m_tuser),  128'(0));
      chk("rst_m_tlast",  128'(m_tlast),  128'(0));
      chk("rst_pass",     128'(pass_cnt), 128'(0));
      chk("rst_drop",     128'(drop_cnt), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);

      // 3-beat pass, dst 0x01; later-beat TUSER must be zeroed
      m_tready = 1'b1;
      base = q_data.size();
      chk("t1_pre_vld", 128'(m_tvalid), 128'(0));
      beat(64'h1111_0000_0000_0010, 128'h01AB_CDEF, 8'hFF, 1'b0);
      chk("t1_lat_vld",  128'(m_tvalid), 128'(1));
      chk("t1_lat_data", 128'(m_tdata),  128'h1111_0000_0000_0010);
      chk("t1_lat_user", 128'(m_tuser),  128'h01AB_CDEF);
      beat(64'h1111_0000_0000_0011, 128'h0123_4567, 8'hFF, 1'b0);
      beat(64'h1111_0000_0000_0012, 128'h0123_4567, 8'hFF, 1'b1);
      idle(3);
      chk("t1_count", 128'(q_data.size() - base), 128'(3));
      chk_out("t1_b0", base + 0, 64'h1111_0000_0000_0010, 128'h01AB_CDEF, 8'hFF, 1'b0);
      chk_out("t1_b1", base + 1, 64'h1111_0000_0000_0011, 128'h0,         8'hFF, 1'b0);
      chk_out("t1_b2", base + 2, 64'h1111_0000_0000_0012, 128'h0,         8'hFF, 1'b1);
      chk("t1_pass", 128'(pass_cnt), 128'(1));
      chk("t1_drop", 128'(drop_cnt), 128'(0));

      // 4-beat drop, dst 0x00 with other TUSER bits set
      base  = q_data.size();
      vbase = vld_seen;
      beat(64'h2222_0000_0000_0020, 128'hFFFF_0000_00EE_EEEE, 8'hFF, 1'b0);
      chk("t2_rdy0", 128'(last_waits), 128'(0));
      beat(64'h2222_0000_0000_0021, 128'h0, 8'hFF, 1'b0);
      chk("t2_rdy1", 128'(last_waits), 128'(0));
      beat(64'h2222_0000_0000_0022, 128'h0, 8'hFF, 1'b0);
      chk("t2_rdy2", 128'(last_waits), 128'(0));
      beat(64'h2222_0000_0000_0023, 128'h0, 8'hFF, 1'b1);
      chk("t2_rdy3", 128'(last_waits), 128'(0));
      idle(2);
      chk("t2_no_beats", 128'(q_data.size() - base), 128'(0));
      chk("t2_no_vld",   128'(vld_seen - vbase),     128'(0));
      chk("t2_drop", 128'(drop_cnt), 128'(1));
      chk("t2_pass", 128'(pass_cnt), 128'(1));

      // 6-beat pass with output stalled: buffer fills and holds its head
      base = q_data.size();
      beat(64'h3333_0000_0000_0030, 128'h0200_0001, 8'hFF, 1'b0);
      m_tready = 1'b0;
      beat(64'h3333_0000_0000_0031, 128'h0, 8'hFF, 1'b0);
      s_tdata  = 64'h3333_0000_0000_0032;
      s_tuser  = 128'h0;
      s_tkeep  = 8'hFF;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_full_rdy",  128'(s_tready), 128'(0));
         chk("t3_hold_vld",  128'(m_tvalid), 128'(1));
         chk("t3_hold_data", 128'(m_tdata),  128'h3333_0000_0000_0030);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      beat(64'h3333_0000_0000_0032, 128'h0, 8'hFF, 1'b0);
      beat(64'h3333_0000_0000_0033, 128'h0, 8'hFF, 1'b0);
      beat(64'h3333_0000_0000_0034, 128'h0, 8'hFF, 1'b0);
      beat(64'h3333_0000_0000_0035, 128'h0, 8'hFF, 1'b1);
      idle(4);
      chk("t3_count", 128'(q_data.size() - base), 128'(6));
      chk_out("t3_b0", base + 0, 64'h3333_0000_0000_0030, 128'h0200_0001, 8'hFF, 1'b0);
      chk_out("t3_b1", base + 1, 64'h3333_0000_0000_0031, 128'h0, 8'hFF, 1'b0);
      chk_out("t3_b2", base + 2, 64'h3333_0000_0000_0032, 128'h0, 8'hFF, 1'b0);
      chk_out("t3_b3", base + 3, 64'h3333_0000_0000_0033, 128'h0, 8'hFF, 1'b0);
      chk_out("t3_b4", base + 4, 64'h3333_0000_0000_0034, 128'h0, 8'hFF, 1'b0);
      chk_out("t3_b5", base + 5, 64'h3333_0000_0000_0035, 128'h0, 8'hFF, 1'b1);
      chk("t3_pass", 128'(pass_cnt), 128'(2));

      // contiguous stream: pass(1, dst 0x04, zero tkeep), drop(2), pass(2, dst 0x10)
      base = q_data.size();
      beat(64'h4444_0000_0000_0040, 128'h0400_0001, 8'h00, 1'b1);
      beat(64'h4444_0000_0000_0041, 128'h00FF_FFFF, 8'hFF, 1'b0);
      beat(64'h4444_0000_0000_0042, 128'hFF00_0000, 8'hFF, 1'b1);
      beat(64'h4444_0000_0000_0043, 128'h1000_0055, 8'h0F, 1'b0);
      beat(64'h4444_0000_0000_0044, 128'h7F00_0000, 8'hFF, 1'b1);
      idle(3);
      chk("t4_count", 128'(q_data.size() - base), 128'(3));
      chk_out("t4_b0", base + 0, 64'h4444_0000_0000_0040, 128'h0400_0001, 8'h00, 1'b1);
      chk_out("t4_b1", base + 1, 64'h4444_0000_0000_0043, 128'h1000_0055, 8'h0F, 1'b0);
      chk_out("t4_b2", base + 2, 64'h4444_0000_0000_0044, 128'h0,         8'hFF, 1'b1);
      chk("t4_pass", 128'(pass_cnt), 128'(4));
      chk("t4_drop", 128'(drop_cnt), 128'(2));

      // clear coincident with an accepted tlast, then drop-counter saturation
      clear = 1'b1;
      beat(64'h5555_0000_0000_0050, 128'h0, 8'hFF, 1'b1);
      clear = 1'b0;
      chk("t5_clr_pass", 128'(pass_cnt), 128'(0));
      chk("t5_clr_drop", 128'(drop_cnt), 128'(0));
      for (int i = 0; i < 15; i++) beat(64'h5555_0000_0000_0051, 128'h0, 8'hFF, 1'b1);
      chk("t5_drop15", 128'(drop_cnt), 128'(15));
      for (int i = 0; i < 2; i++) beat(64'h5555_0000_0000_0052, 128'h0, 8'hFF, 1'b1);
      chk("t5_drop_sat", 128'(drop_cnt), 128'(15));
      chk("t5_pass", 128'(pass_cnt), 128'(0));

      // reset in the middle of a buffered pass packet
      beat(64'h6666_0000_0000_0060, 128'h0100_0000, 8'hFF, 1'b1);
      idle(2);
      chk("t6_pre_pass", 128'(pass_cnt), 128'(1));
      m_tready = 1'b0;
      beat(64'h6666_0000_0000_0061, 128'h0100_0000, 8'hFF, 1'b0);
      beat(64'h6666_0000_0000_0062, 128'h0, 8'hFF, 1'b0);
      @(negedge clk);
      chk("t6_pre_vld", 128'(m_tvalid), 128'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_vld",  128'(m_tvalid), 128'(0));
      chk("t6_rst_rdy",  128'(s_tready), 128'(0));
      chk("t6_rst_pass", 128'(pass_cnt), 128'(0));
      chk("t6_rst_drop", 128'(drop_cnt), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_tready = 1'b1;
      base = q_data.size();
      beat(64'h6666_0000_0000_0063, 128'h0100_0000, 8'hFF, 1'b0);
      beat(64'h6666_0000_0000_0064, 128'h0100_0000, 8'hFF, 1'b1);
      idle(3);
      chk("t6_count", 128'(q_data.size() - base), 128'(2));
      chk_out("t6_b0", base + 0, 64'h6666_0000_0000_0063, 128'h0100_0000, 8'hFF, 1'b0);
      chk_out("t6_b1", base + 1, 64'h6666_0000_0000_0064, 128'h0,         8'hFF, 1'b1);
      chk("t6_pass", 128'(pass_cnt), 128'(1));
      chk("t6_drop", 128'(drop_cnt), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
